// File: rtl/ofifo_drain_pkg.sv
// Shared types and default geometry for the ofifo read-side drain controller.
package ofifo_drain_pkg;

  localparam int COL_DEF     = 8;
  localparam int PSUM_BW_DEF = 16;
  localparam int ADDR_BW_DEF = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/psum_relu.sv
// One psum lane: passes the value through, or clamps negatives to zero when enabled.
module psum_relu #(
  parameter int psum_bw = 16
) (
  input  logic               relu_en,
  input  logic [psum_bw-1:0] din,
  output logic [psum_bw-1:0] dout
);

  assign dout = (relu_en && din[psum_bw-1]) ? '0 : din;

endmodule

// File: rtl/ofifo_drain.sv
// Pops complete psum rows from the ofifo, applies optional ReLU and writes them to
// consecutive psum SRAM addresses under write backpressure; pulses done at job end.
module ofifo_drain
  import ofifo_drain_pkg::*;
#(
  parameter int col     = COL_DEF,
  parameter int psum_bw = PSUM_BW_DEF,
  parameter int addr_bw = ADDR_BW_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     num_rows,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic                   relu_en,
  input  logic                   fifo_valid,
  input  logic [col*psum_bw-1:0] fifo_out,
  output logic                   fifo_rd,
  output logic                   mem_wen,
  output logic [addr_bw-1:0]     mem_addr,
  output logic [col*psum_bw-1:0] mem_d,
  input  logic                   mem_ready,
  output logic                   busy,
  output logic                   done
);

  state_t                 state_reg;
  logic [addr_bw-1:0]     num_rows_reg;
  logic [addr_bw-1:0]     rd_cnt_reg;
  logic [addr_bw-1:0]     wr_cnt_reg;
  logic [addr_bw-1:0]     mem_addr_reg;
  logic                   relu_reg;
  logic                   out_vld_reg;
  logic [col*psum_bw-1:0] mem_d_reg;
  logic [col*psum_bw-1:0] relu_row;
  logic [addr_bw-1:0]     wr_cnt_next;
  logic                   pop;
  logic                   accept;

  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      psum_relu #(.psum_bw(psum_bw)) u_relu (
        .relu_en (relu_reg),
        .din     (fifo_out[gi*psum_bw +: psum_bw]),
        .dout    (relu_row[gi*psum_bw +: psum_bw])
      );
    end
  endgenerate

  // A pop may refill the output register in the same cycle its old row is accepted.
  assign pop         = (state_reg == DRAIN) && fifo_valid && (rd_cnt_reg < num_rows_reg)
                       && (!out_vld_reg || mem_ready);
  assign accept      = out_vld_reg && mem_ready;
  assign wr_cnt_next = wr_cnt_reg + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      num_rows_reg <= '0;
      rd_cnt_reg   <= '0;
      wr_cnt_reg   <= '0;
      mem_addr_reg <= '0;
      relu_reg     <= 1'b0;
      out_vld_reg  <= 1'b0;
      mem_d_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            num_rows_reg <= num_rows;
            mem_addr_reg <= base_addr;
            relu_reg     <= relu_en;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
            out_vld_reg  <= 1'b0;
            state_reg    <= (num_rows == '0) ? DONE : DRAIN;
          end
        end
        DRAIN: begin
          if (pop) begin
            rd_cnt_reg  <= rd_cnt_reg + 1'b1;
            out_vld_reg <= 1'b1;
            mem_d_reg   <= relu_row;
          end else if (accept) begin
            out_vld_reg <= 1'b0;
          end
          if (accept) begin
            wr_cnt_reg   <= wr_cnt_next;
            mem_addr_reg <= mem_addr_reg + 1'b1;
            if (wr_cnt_next == num_rows_reg) begin
              state_reg <= DONE;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign fifo_rd  = pop;
  assign mem_wen  = out_vld_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_d    = mem_d_reg;
  assign busy     = (state_reg != IDLE);
  assign done     = (state_reg == DONE);

endmodule

// File: doc/ofifo_drain.md
# ofifo_drain

Read-side controller for the output FIFO of the systolic core. It pops complete psum rows (all `col` lanes present) from the ofifo and applies optional per-lane ReLU. Each row is written to the psum SRAM write port at consecutive addresses, under memory backpressure. It sits between the ofifo and the psum memory and signals `done` once a programmed number of rows has been written.

## Interface
- `col` — 8 — psum lanes per row (must match ofifo)
- `psum_bw` — 16 — bits per lane, two's complement
- `addr_bw` — 11 — psum SRAM address width
- `clk` input 1 — single clock, all state on rising edge
- `reset` input 1 — asynchronous, active-high; clears all state
- `start` input 1 — one-cycle pulse; launches a drain job (ignored while `busy`)
- `num_rows` input addr_bw — rows to drain, sampled on accepted `start`
- `base_addr` input addr_bw — first SRAM address, sampled on accepted `start`
- `relu_en` input 1 — clamp negative lanes to 0, sampled on accepted `start`
- `fifo_valid` input 1 — ofifo `o_valid`: every lane non-empty, head row on `fifo_out`
- `fifo_out` input col*psum_bw — ofifo head row, combinational
- `fifo_rd` output 1 — to ofifo `rd`; pops head row of all lanes at this edge
- `mem_wen` output 1 — write request, data/addr valid
- `mem_addr` output addr_bw — write address
- `mem_d` output col*psum_bw — write data, lane i at bits [(i+1)*psum_bw-1 : i*psum_bw]
- `mem_ready` input 1 — SRAM accepts write when `mem_wen & mem_ready`
- `busy` output 1 — job in progress
- `done` output 1 — one-cycle pulse after last row accepted

## Operation
- States: IDLE, DRAIN, DONE.
- IDLE → DRAIN on `start`:
  - latch `num_rows`, `base_addr`, `relu_en`
  - clear pop counter `rd_cnt` and write counter `wr_cnt`
- IDLE → DONE directly if `start` with `num_rows`=0. No pop, no write.
- DRAIN:
  - `fifo_rd = fifo_valid & (rd_cnt < num_rows) & (~out_vld | mem_ready)`
  - A pop loads the output register `out_vld`/`mem_d` with `fifo_out`, ReLU'd per lane if enabled. The ReLU test is the lane's sign bit.
- Output register:
  - `mem_wen = out_vld`
  - on `mem_wen & mem_ready`: `wr_cnt++`, `mem_addr++` (wraps mod 2^addr_bw)
  - `out_vld` clears unless a new pop occurs in the same cycle.
- Accepted write with `wr_cnt+1 == num_rows` → DONE.
- DONE → IDLE after exactly one cycle. `done` = (state==DONE).
- `busy` = (state != IDLE).
- Never pops more than `num_rows` rows; rows beyond stay in the ofifo.
- `fifo_rd` is never asserted in IDLE or DONE, or when `fifo_valid`=0. Partial rows (some lanes empty) are never popped.
- Reset mid-job: returns to IDLE, discards the held row. The ofifo is not flushed.

## Timing
- Reset values: `fifo_rd`=0, `mem_wen`=0, `mem_addr`=0, `mem_d`=0, `busy`=0, `done`=0.
- `start` at edge t: `busy`=1 from t+1. The earliest `fifo_rd` is cycle t+1.
- Pop at edge p: row appears on `mem_d` with `mem_wen`=1 in cycle p+1. Pop-to-write latency is 1 cycle.
- Throughput is 1 row/cycle while `fifo_valid`=1 and `mem_ready`=1.
- `mem_ready`=0 with `out_vld`=1: hold `mem_wen`, `mem_addr`, `mem_d` stable. `fifo_rd`=0.
- Pop and write-accept in the same cycle are legal (register replaced).
- Last write accepted at edge w: `done`=1 in cycle w+1, `busy`=0 in cycle w+2.

## Structure
- Package `ofifo_drain_pkg`:
  - state enum {IDLE, DRAIN, DONE}
  - default `col`/`psum_bw`/`addr_bw` constants
- Sub-module `psum_relu` (`psum_bw`): one lane, passes the value or clamps it to 0. Instantiated `col` times in a generate loop.

## Test plan
- Basic drain: preload 4 rows, lane i = 16*r+i. `start`, `num_rows`=4, `base_addr`=0x10, `mem_ready`=1.
  - Writes at 0x10..0x13 in 4 consecutive cycles, data exact.
  - `done` 1 cycle after the 4th write, `fifo_rd` count = 4.
- ReLU: row lanes {-1, 5, -32768, 32767, 0, -7, 1, -2}, `relu_en`=1 → `mem_d` lanes {0, 5, 0, 32767, 0, 0, 1, 0}. Same row with `relu_en`=0 → unchanged.
- Backpressure: `mem_ready` low for 3 cycles during row 2 of 5.
  - `mem_d`/`mem_addr` held, no `fifo_rd` while stalled.
  - All 5 rows written in order, no loss or duplicate.
- Partial/empty FIFO: `fifo_valid` toggles 1,0,0,1 with 2 rows requested → `fifo_rd` only when `fifo_valid`=1. Third row left in the FIFO.
- Edges:
  - `num_rows`=0: `done` without any `mem_wen`.
  - `base_addr`=0x7FE, 3 rows: addresses 0x7FE, 0x7FF, 0x000.
  - `start` while busy is ignored.
- Reset mid-job after 2 of 6 writes:
  - all outputs 0 immediately (async)
  - IDLE after deassert; a new `start` works normally.
